// File: rtl/pipe_skid_stage_t_if.sv
// Valid/ready handshake bundle for both sides of pipe_skid_stage_t.
// The slave modport is the stage itself; the master modport is the surrounding pipeline.
interface pipe_skid_stage_t_if #(
    parameter int unsigned BIT_WIDTH = 8
) ();
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [BIT_WIDTH-1:0] IN_DATA;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [BIT_WIDTH-1:0] OUT_DATA;

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output OUT_DATA
    );

    modport master (
        output IN_VALID,
        output IN_DATA,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  OUT_DATA
    );
endinterface

// File: rtl/pipe_skid_stage_t.sv
// Two-entry valid/ready skid stage: registered IN_READY/OUT_VALID, full throughput,
// synchronous flush. Head register drives OUT_DATA; skid register catches the stalled beat.
module pipe_skid_stage_t #(
    parameter int unsigned          BIT_WIDTH     = 8,
    parameter logic [BIT_WIDTH-1:0] DEFAULT_VALUE = {BIT_WIDTH{1'b0}}
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    pipe_skid_stage_t_if.slave       bus,
    output logic [1:0]               OCCUPANCY
);
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [OCC_W-1:0]     occ_q;
    logic [BIT_WIDTH-1:0] head_q;
    logic [BIT_WIDTH-1:0] skid_q;

    logic accept_c;
    logic drain_c;
    logic head_we_c;
    logic skid_we_c;
    logic head_from_skid_c;

    assign accept_c = bus.IN_VALID & in_ready_q;
    assign drain_c  = out_valid_q & bus.OUT_READY;

    // Per-register write enables; flush suppresses all payload writes.
    always_comb begin
        head_we_c        = 1'b0;
        skid_we_c        = 1'b0;
        head_from_skid_c = 1'b0;
        if (!FLUSH) begin
            case (state_q)
                EMPTY: head_we_c = accept_c;
                FULL: begin
                    head_we_c = accept_c & drain_c;
                    skid_we_c = accept_c & ~drain_c;
                end
                SKID: begin
                    head_we_c        = drain_c;
                    head_from_skid_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head_q <= DEFAULT_VALUE;
            skid_q <= DEFAULT_VALUE;
        end else begin
            if (head_we_c) head_q <= head_from_skid_c ? skid_q : bus.IN_DATA;
            if (skid_we_c) skid_q <= bus.IN_DATA;
        end
    end

    // State machine; handshake outputs are registered alongside the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= OCC_W'(0);
        end else if (FLUSH) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= OCC_W'(0);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        state_q     <= FULL;
                        out_valid_q <= 1'b1;
                        occ_q       <= OCC_W'(1);
                    end
                end
                FULL: begin
                    if (accept_c && !drain_c) begin
                        state_q    <= SKID;
                        in_ready_q <= 1'b0;
                        occ_q      <= OCC_W'(2);
                    end else if (!accept_c && drain_c) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                        occ_q       <= OCC_W'(0);
                    end
                end
                SKID: begin
                    if (drain_c) begin
                        state_q    <= FULL;
                        in_ready_q <= 1'b1;
                        occ_q      <= OCC_W'(1);
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    occ_q       <= OCC_W'(0);
                end
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = head_q;
    assign OCCUPANCY     = occ_q;
endmodule

// File: tb/tb_pipe_skid_stage_t.sv
// Self-checking bench for pipe_skid_stage_t: directed vector table, hand sequences,
// and a randomized run against a queue-based reference model.
module tb_pipe_skid_stage_t;
    localparam int unsigned W = 8;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b0;
    logic       FLUSH = 1'b0;
    logic [1:0] occupancy;

    pipe_skid_stage_t_if #(.BIT_WIDTH(W)) bus ();

    pipe_skid_stage_t #(.BIT_WIDTH(W), .DEFAULT_VALUE(8'h00)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .FLUSH    (FLUSH),
        .bus      (bus),
        .OCCUPANCY(occupancy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       ev;
        logic       er;
        logic [1:0] eo;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl[15];

    // Reference model: entries held, in order, plus the last head value shown.
    logic [7:0] mq[$];
    logic [7:0] m_head;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic er,
                              input logic [1:0] eo, input logic [7:0] ed);
        chk({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'(ev));
        chk({tag, "_in_ready"}, 32'(bus.IN_READY), 32'(er));
        chk({tag, "_occupancy"}, 32'(occupancy), 32'(eo));
        chk({tag, "_out_data"}, 32'(bus.OUT_DATA), 32'(ed));
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        bus.IN_VALID  = iv;
        bus.IN_DATA   = d;
        bus.OUT_READY = ordy;
        FLUSH         = fl;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic       hold;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ready;
        logic       e_valid;
        logic       acc;
        logic       drn;

        //             iv  d      ordy fl   ev   er   eo     ed
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h22};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h22};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        tbl[7]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h11};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h11};
        tbl[9]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h11};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h11};
        tbl[11] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h3C};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3C};
        tbl[13] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
        tbl[14] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h44};

        // Power-on reset
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        RST = 1'b0;
        #12;
        check_outs("por", 1'b0, 1'b1, 2'd0, 8'h00);
        @(negedge CLK);
        RST = 1'b1;

        // Directed vector table: skid, drain, flush collisions
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].eo, tbl[i].ed);
        end

        // Back-to-back streaming at full throughput
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            tick();
            check_outs($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 8'(i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check_outs("stream_end", 1'b0, 1'b1, 2'd0, 8'h10);

        // Asynchronous reset mid-cycle with two entries held
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hBB, 1'b0, 1'b0);
        tick();
        check_outs("prerst", 1'b1, 1'b0, 2'd2, 8'hAA);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        check_outs("midrst", 1'b0, 1'b1, 2'd0, 8'h00);
        @(negedge CLK);
        RST = 1'b1;
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        tick();
        check_outs("postrst", 1'b1, 1'b1, 2'd1, 8'hA5);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check_outs("postrst_drain", 1'b0, 1'b1, 2'd0, 8'hA5);

        // Randomized run against the queue model, starting from reset
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        RST = 1'b0;
        #2;
        @(negedge CLK);
        RST = 1'b1;
        mq.delete();
        m_head = 8'h00;
        hold = 1'b0;
        iv = 1'b0;
        d = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                iv = ($urandom_range(0, 99) < 70);
                d  = 8'($urandom);
            end
            ordy = ($urandom_range(0, 99) < 60);
            fl   = ($urandom_range(0, 99) < 5);
            drive(iv, d, ordy, fl);
            e_ready = (mq.size() != 2);
            e_valid = (mq.size() != 0);
            acc = iv & e_ready;
            drn = e_valid & ordy;
            #3;
            chk("rnd_in_ready_mid", 32'(bus.IN_READY), 32'(e_ready));
            chk("rnd_out_valid_mid", 32'(bus.OUT_VALID), 32'(e_valid));
            tick();
            if (fl) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(d);
                if (mq.size() != 0) m_head = mq[0];
            end
            check_outs("rnd", mq.size() != 0, mq.size() != 2, 2'(mq.size()), m_head);
            hold = iv & ~acc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
